// File: rtl/dm_cache_ctrl_pkg.sv
// Shared widths, state type and block helpers for the direct-mapped cache.
// Address split: [9:6] tag, [5:4] index, [3:2] word, [1:0] byte.
package dm_cache_ctrl_pkg;

    localparam int ADDR_W    = 10;
    localparam int WORD_W    = 32;
    localparam int TAG_W     = 4;
    localparam int IDX_W     = 2;
    localparam int OFF_W     = 4;
    localparam int WSEL_W    = 2;
    localparam int BLOCK_W   = 128;
    localparam int NUM_LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITEBACK,
        S_ALLOCATE,
        S_DONE
    } state_e;

    // Word 0 sits in the most significant slot of a block.
    function automatic logic [WORD_W-1:0] get_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [WSEL_W-1:0]  w
    );
        return blk[BLOCK_W-1-WORD_W*int'(w) -: WORD_W];
    endfunction

    function automatic logic [ADDR_W-1:0] blk_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx
    );
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays for the cache lines.
// One indexed line port; a fill takes priority over a word write.
module cache_line_store
    import dm_cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [WSEL_W-1:0]  wr_word,
    input  logic [WORD_W-1:0]  wr_wdata,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];
    logic [BLOCK_W-1:0]   data_d [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = fill_tag;
            data_d[idx]  = fill_data;
        end else if (wr_en) begin
            data_d[idx][BLOCK_W-1-WORD_W*int'(wr_word) -: WORD_W] = wr_wdata;
            dirty_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller.
// Sequences hit handling, dirty-line writeback and block refill.
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BLOCK_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_we_q, req_we_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic [WSEL_W-1:0]  req_word_q, req_word_d;
    logic [WORD_W-1:0]  req_wdata_q, req_wdata_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               wr_en;
    logic               fill_en;
    logic               unused_byte_sel;

    assign unused_byte_sel = ^cpu_addr[1:0];

    cache_line_store u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (req_idx_q),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (wr_en),
        .wr_word   (req_word_q),
        .wr_wdata  (req_wdata_q),
        .fill_en   (fill_en),
        .fill_tag  (req_tag_q),
        .fill_data (mem_rdata)
    );

    assign hit       = line_valid && (line_tag == req_tag_q);
    assign cpu_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_word_d  = req_word_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        cpu_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    req_we_d    = cpu_req_we;
                    req_tag_d   = cpu_addr[9:6];
                    req_idx_d   = cpu_addr[5:4];
                    req_word_d  = cpu_addr[3:2];
                    req_wdata_d = cpu_wdata;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    if (req_we_q) begin
                        wr_en = 1'b1;
                    end else begin
                        rdata_d = get_word(line_data, req_word_q);
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = (line_valid && line_dirty) ? S_WRITEBACK
                                                         : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                mem_we    = 1'b1;
                mem_addr  = blk_addr(line_tag, req_idx_q);
                mem_wdata = line_data;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ALLOCATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ALLOCATE: begin
                mem_addr = blk_addr(req_tag_q, req_idx_q);
                // Refill lands on the final cycle; the retried CHECK then hits.
                if (cnt_q == CNT_LAST) begin
                    fill_en = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_we_q    <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_we_q    <= req_we_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_word_q  <= req_word_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl against a flat-memory reference.
// A monitor pops expected responses whenever cpu_ready pulses.
module tb_dm_cache_ctrl;

    localparam int MEM_LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_we = 1'b0;
    logic [9:0]   cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    dm_cache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_we    (cpu_req_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main memory: combinational read, write on rising edge while mem_we.
    logic [127:0] mem_blk [64];
    assign mem_rdata = mem_blk[mem_addr[9:4]];
    always @(posedge clk) if (mem_we) mem_blk[mem_addr[9:4]] = mem_wdata;

    // Reference: what the CPU should see is a flat word memory; the
    // line bookkeeping below only predicts latency and evictions.
    logic [31:0] ref_words [256];
    logic [3:0]  ref_tag   [4];
    logic        ref_valid [4];
    logic        ref_dirty [4];
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] rdata;
        int          start;
        int          lat;
        int          wb;
        logic [9:0]  wb_addr;
    } exp_t;

    exp_t sb [$];
    int checks = 0;
    int errors = 0;
    int wb_cnt = 0;
    int wb_bad = 0;

    function automatic void check(string name, logic [127:0] act,
                                  logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wb_cnt = 0;
                wb_bad = 0;
            end else begin
                if (mem_we) begin
                    wb_cnt++;
                    if (sb.size() == 0 || mem_addr !== sb[0].wb_addr) wb_bad++;
                end
                if (cpu_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_ready: got 1 expected 0");
                    end else begin
                        e = sb.pop_front();
                        check("rdata", cpu_rdata, e.rdata);
                        check("latency", cyc - e.start, e.lat);
                        check("wb_cycles", wb_cnt, e.wb);
                        check("wb_addr_errs", wb_bad, 0);
                    end
                    wb_cnt = 0;
                    wb_bad = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_seen", seen, 1'b1);
        if (!seen) sb.delete();
        @(negedge clk);
    endtask

    // Called on a falling edge while the DUT sits in IDLE.
    task automatic issue(input logic we, input logic [9:0] addr,
                         input logic [31:0] wd);
        exp_t e;
        logic [1:0] idx;
        logic [3:0] tag;
        logic [7:0] wi;
        idx = addr[5:4];
        tag = addr[9:6];
        wi  = addr[9:2];
        e.wb = 0;
        e.wb_addr = '0;
        if (ref_valid[idx] && ref_tag[idx] == tag) begin
            e.lat = 2;
        end else begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                e.lat = 2 * MEM_LAT + 3;
                e.wb = MEM_LAT;
                e.wb_addr = {ref_tag[idx], idx, 4'h0};
            end else begin
                e.lat = MEM_LAT + 3;
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx] = tag;
            ref_dirty[idx] = 1'b0;
        end
        if (we) begin
            ref_words[wi] = wd;
            ref_dirty[idx] = 1'b1;
            e.rdata = last_rd;
        end else begin
            e.rdata = ref_words[wi];
            last_rd = e.rdata;
        end
        e.start = cyc;
        sb.push_back(e);
        cpu_req_valid = 1'b1;
        cpu_req_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        // Junk on the request lines while busy must be ignored.
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'($urandom);
        cpu_addr = 10'($urandom);
        cpu_wdata = $urandom;
        wait_ready();
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_ready"}, cpu_ready, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin : driver
        logic [9:0] a;
        for (int b = 0; b < 64; b++) begin
            mem_blk[b] = {$urandom, $urandom, $urandom, $urandom};
            for (int w = 0; w < 4; w++)
                ref_words[b*4+w] = mem_blk[b][127-32*w -: 32];
        end
        for (int i = 0; i < 4; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i] = '0;
        end
        last_rd = '0;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 10'h000, 32'h0);
        issue(1'b0, 10'h004, 32'h0);
        issue(1'b1, 10'h004, 32'h12345678);
        issue(1'b0, 10'h004, 32'h0);
        issue(1'b0, 10'h104, 32'h0);
        issue(1'b0, 10'h004, 32'h0);

        // Abort a refill in its third ALLOCATE cycle.
        cpu_req_valid = 1'b1;
        cpu_req_we = 1'b0;
        cpu_addr = 10'h208;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("alloc_addr", mem_addr, 10'h200);
        check("alloc_we", mem_we, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        last_rd = '0;
        @(negedge clk);

        issue(1'b0, 10'h208, 32'h0);
        issue(1'b0, 10'h004, 32'h0);

        for (int n = 0; n < 300; n++) begin
            a = {4'($urandom_range(0, 2)), 6'($urandom)};
            issue(1'($urandom), a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
